// File: rtl/biquad_pkg.sv
// Shared types and constants for the biquad sequencing datapath.
// Fixed-point formats: Q2.14 samples/coefficients, Q4.28 accumulator.
package biquad_pkg;

  typedef logic signed [15:0] q2_14_t;
  typedef logic signed [31:0] q4_28_t;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ISSUE,
    DRAIN,
    OUTPUT
  } seq_state_e;

  localparam int NUM_TERMS = 5;
  localparam logic [31:0] ROUND_BIAS = 32'h2000;

  // Two's-complement negation that maps the most negative code to the most positive one.
  function automatic q2_14_t neg_sat(input q2_14_t v);
    if (v == 16'sh8000) begin
      return 16'sh7FFF;
    end
    return -v;
  endfunction

endpackage

// File: rtl/q4_28_to_q2_14_sat.sv
// Combinational round-half-up and saturate from a Q4.28 accumulator to a Q2.14 sample.
module q4_28_to_q2_14_sat
  import biquad_pkg::*;
(
  input  logic [31:0] acc_i,
  output logic [15:0] sample_o
);

  // One guard bit so the rounding add can never wrap near full scale.
  logic [32:0] sum;
  logic        fits;
  logic        unused_low_bits;

  assign sum  = {acc_i[31], acc_i} + {1'b0, ROUND_BIAS};
  assign fits = (sum[32:29] == 4'b0000) || (sum[32:29] == 4'b1111);
  assign unused_low_bits = ^sum[13:0];

  always_comb begin
    sample_o = sum[29:14];
    if (!fits) begin
      sample_o = sum[32] ? 16'h8000 : 16'h7FFF;
    end
  end

endmodule

// File: rtl/biquad_mac_sequencer.sv
// Direct-Form-I biquad controller: feeds five coefficient/sample products per input sample
// into an external MAC, then rounds the accumulated result and updates the x/y delay line.
module biquad_mac_sequencer
  import biquad_pkg::*;
#(
  parameter int MAC_LATENCY  = 2,
  parameter int CLEAR_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sample_valid,
  input  logic [15:0] sample_in,
  input  logic [15:0] coef_b0,
  input  logic [15:0] coef_b1,
  input  logic [15:0] coef_b2,
  input  logic [15:0] coef_a1,
  input  logic [15:0] coef_a2,
  output logic        mac_rst,
  output logic        mac_ce,
  output logic [15:0] mac_a,
  output logic [15:0] mac_b,
  input  logic [31:0] mac_result,
  output logic [15:0] y_out,
  output logic        y_valid,
  output logic        busy,
  output logic        overrun
);

  localparam int CNT_W = 4;

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       term_q, term_d;

  q2_14_t x_q, x1_q, x2_q, y1_q, y2_q;
  q2_14_t b0_q, b1_q, b2_q, a1_q, a2_q;
  q2_14_t y_out_q;
  logic   y_valid_q;
  logic   overrun_q;
  logic   accept;
  logic [15:0] y_new;

  assign accept = sample_valid && (state_q == IDLE);

  q4_28_to_q2_14_sat u_sat (
    .acc_i    (mac_result),
    .sample_o (y_new)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      term_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      term_q  <= term_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    term_d  = term_q;
    case (state_q)
      IDLE: begin
        if (sample_valid) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        if (cnt_q == CNT_W'(CLEAR_CYCLES - 1)) begin
          state_d = ISSUE;
          cnt_d   = '0;
          term_d  = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ISSUE: begin
        if (term_q == 3'(NUM_TERMS - 1)) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end else begin
          term_d = term_q + 1'b1;
        end
      end
      DRAIN: begin
        if (cnt_q == CNT_W'(MAC_LATENCY - 1)) begin
          state_d = OUTPUT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      OUTPUT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Operand mux: feedback coefficients are negated so the MAC only ever adds.
  always_comb begin
    mac_a = '0;
    mac_b = '0;
    if (state_q == ISSUE) begin
      case (term_q)
        3'd0: begin mac_a = b0_q;          mac_b = x_q;  end
        3'd1: begin mac_a = b1_q;          mac_b = x1_q; end
        3'd2: begin mac_a = b2_q;          mac_b = x2_q; end
        3'd3: begin mac_a = neg_sat(a1_q); mac_b = y1_q; end
        3'd4: begin mac_a = neg_sat(a2_q); mac_b = y2_q; end
        default: begin mac_a = '0;         mac_b = '0;   end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q       <= '0;
      x1_q      <= '0;
      x2_q      <= '0;
      y1_q      <= '0;
      y2_q      <= '0;
      b0_q      <= '0;
      b1_q      <= '0;
      b2_q      <= '0;
      a1_q      <= '0;
      a2_q      <= '0;
      y_out_q   <= '0;
      y_valid_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      y_valid_q <= (state_q == OUTPUT);
      if (accept) begin
        x_q  <= sample_in;
        b0_q <= coef_b0;
        b1_q <= coef_b1;
        b2_q <= coef_b2;
        a1_q <= coef_a1;
        a2_q <= coef_a2;
      end
      if (sample_valid && (state_q != IDLE)) begin
        overrun_q <= 1'b1;
      end
      if (state_q == OUTPUT) begin
        y_out_q <= y_new;
        y1_q    <= y_new;
        y2_q    <= y1_q;
        x1_q    <= x_q;
        x2_q    <= x1_q;
      end
    end
  end

  // The MAC is held in clear throughout reset as well as during CLEAR.
  assign mac_rst = ~reset && (state_q != CLEAR);
  assign mac_ce  = (state_q == ISSUE);
  assign y_out   = y_out_q;
  assign y_valid = y_valid_q;
  assign busy    = (state_q != IDLE);
  assign overrun = overrun_q;

endmodule

// File: tb/tb_biquad_mac_sequencer.sv
// Bench for biquad_mac_sequencer paired with a behavioural two-stage MAC; expected outputs
// come from a DF-I reference model and are queued at accept time, compared at y_valid.
module tb_biquad_mac_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        sample_valid;
  logic [15:0] sample_in;
  logic [15:0] coef_b0, coef_b1, coef_b2, coef_a1, coef_a2;
  logic        mac_rst, mac_ce;
  logic [15:0] mac_a, mac_b;
  logic [31:0] mac_result;
  logic [15:0] y_out;
  logic        y_valid, busy, overrun;

  int checks_cnt = 0;
  int errors_cnt = 0;

  logic [15:0] exp_q[$];
  logic signed [15:0] mx1, mx2, my1, my2;

  always #5 clk = ~clk;

  biquad_mac_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (sample_valid),
    .sample_in    (sample_in),
    .coef_b0      (coef_b0),
    .coef_b1      (coef_b1),
    .coef_b2      (coef_b2),
    .coef_a1      (coef_a1),
    .coef_a2      (coef_a2),
    .mac_rst      (mac_rst),
    .mac_ce       (mac_ce),
    .mac_a        (mac_a),
    .mac_b        (mac_b),
    .mac_result   (mac_result),
    .y_out        (y_out),
    .y_valid      (y_valid),
    .busy         (busy),
    .overrun      (overrun)
  );

  // Behavioural MAC: registered product, then accumulate (final sum 2 cycles after last ce).
  logic signed [31:0] prod_r, acc_r;
  logic               prod_v;
  always @(posedge clk) begin
    if (!mac_rst) begin
      prod_r <= '0;
      prod_v <= 1'b0;
      acc_r  <= '0;
    end else begin
      prod_v <= mac_ce;
      prod_r <= $signed(mac_a) * $signed(mac_b);
      if (prod_v) acc_r <= acc_r + prod_r;
    end
  end
  assign mac_result = acc_r;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks_cnt++;
    if (obs !== exp_v) begin
      errors_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic signed [15:0] m_neg(input logic signed [15:0] v);
    if (v == 16'sh8000) return 16'sh7FFF;
    return 16'(-int'(v));
  endfunction

  function automatic logic [15:0] m_sat_round(input logic signed [31:0] a);
    longint r;
    r = (longint'(a) + 64'sd8192) >>> 14;
    if (r > 32767) return 16'h7FFF;
    if (r < -32768) return 16'h8000;
    return 16'(r);
  endfunction

  // Reference DF-I step using the coefficients present at the accept edge.
  task automatic model_push(input logic signed [15:0] x);
    longint s;
    logic signed [31:0] acc;
    logic [15:0] y;
    s = longint'($signed(coef_b0)) * longint'(x)
      + longint'($signed(coef_b1)) * longint'(mx1)
      + longint'($signed(coef_b2)) * longint'(mx2)
      + longint'(m_neg($signed(coef_a1))) * longint'(my1)
      + longint'(m_neg($signed(coef_a2))) * longint'(my2);
    acc = 32'(s);
    y = m_sat_round(acc);
    exp_q.push_back(y);
    mx2 = mx1;
    mx1 = x;
    my2 = my1;
    my1 = y;
  endtask

  task automatic set_coefs(input logic [15:0] b0, input logic [15:0] b1, input logic [15:0] b2,
                           input logic [15:0] a1, input logic [15:0] a2);
    coef_b0 = b0; coef_b1 = b1; coef_b2 = b2; coef_a1 = a1; coef_a2 = a2;
  endtask

  // Offer one sample, then wait (bounded) for its y_valid; optionally check cycle-exact timing.
  task automatic send(input logic [15:0] x, input bit lat);
    bit got;
    @(negedge clk);
    sample_in    = x;
    sample_valid = 1'b1;
    @(posedge clk);
    model_push(x);
    @(negedge clk);
    sample_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (i > 0) @(negedge clk);
      if (lat) begin
        if (i < 10) begin
          chk("lat_busy", busy, 1);
          chk("lat_no_yv", y_valid, 0);
        end else if (i == 10) begin
          chk("lat_yv", y_valid, 1);
          chk("lat_idle", busy, 0);
        end
      end
      if (y_valid) got = 1'b1;
    end
    if (!got) chk("yv_timeout", 0, 1);
  endtask

  always @(negedge clk) begin
    if (!reset && y_valid) begin
      if (exp_q.size() == 0) chk("sb_extra", 1, 0);
      else chk("sb_y", y_out, exp_q.pop_front());
    end
  end

  initial begin
    reset = 1'b1;
    sample_valid = 1'b0;
    sample_in = '0;
    set_coefs(16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    mx1 = '0; mx2 = '0; my1 = '0; my2 = '0;
    repeat (3) @(negedge clk);
    chk("rst_mac_rst", mac_rst, 0);
    chk("rst_busy", busy, 0);
    chk("rst_y_out", y_out, 0);
    chk("rst_y_valid", y_valid, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_mac_ce", mac_ce, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_mac_a", mac_a, 0);

    // Impulse response
    set_coefs(16'h2000, 16'h1333, 16'h0CCD, 16'h199A, 16'h0666);
    send(16'h4000, 1'b1);
    chk("imp_y0", y_out, 16'h2000);
    send(16'h0000, 1'b0);
    chk("imp_y1", y_out, 16'h0666);
    send(16'h0000, 1'b0);

    // Saturation
    set_coefs(16'h7FFF, 16'h0, 16'h0, 16'h0, 16'h0);
    send(16'h7FFF, 1'b0);
    chk("sat_pos", y_out, 16'h7FFF);
    send(16'h8000, 1'b0);
    chk("sat_neg", y_out, 16'h8000);

    // Negation of the most negative feedback coefficient
    set_coefs(16'h4000, 16'h0, 16'h0, 16'h0, 16'h0);
    send(16'h4000, 1'b0);
    chk("neg_prep", y_out, 16'h4000);
    set_coefs(16'h0, 16'h0, 16'h0, 16'h8000, 16'h0);
    send(16'h0000, 1'b0);
    chk("neg_sat", y_out, 16'h7FFF);

    // Overrun with a coefficient change mid-flight; both must be ignored
    chk("ovr_clear", overrun, 0);
    set_coefs(16'h2000, 16'h1333, 16'h0CCD, 16'h199A, 16'h0666);
    @(negedge clk);
    sample_in = 16'h4000;
    sample_valid = 1'b1;
    @(posedge clk);
    model_push(16'h4000);
    @(negedge clk);
    sample_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    sample_in = 16'h1234;
    coef_b0 = 16'h7FFF;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    chk("ovr_flag", overrun, 1);
    begin
      bit got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge clk);
        if (y_valid) got = 1'b1;
      end
      if (!got) chk("ovr_timeout", 0, 1);
    end

    // Reset while terms are being issued
    @(negedge clk);
    sample_in = 16'h4000;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_in_issue", mac_ce, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_busy", busy, 0);
    chk("mid_mac_rst", mac_rst, 0);
    chk("mid_overrun", overrun, 0);
    reset = 1'b0;
    mx1 = '0; mx2 = '0; my1 = '0; my2 = '0;
    begin
      int yv_seen = 0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (y_valid) yv_seen++;
      end
      chk("mid_no_yv", yv_seen, 0);
    end
    set_coefs(16'h2000, 16'h1333, 16'h0CCD, 16'h199A, 16'h0666);
    send(16'h4000, 1'b1);
    chk("post_rst_y0", y_out, 16'h2000);

    repeat (3) @(negedge clk);
    chk("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
